cisc_memory: RTL and testbench

- 32-word x 8-bit single-port data/instruction memory for the small CISC SoC.
- The CPU control unit drives it with separate READ and WRITE strobes, a 5-bit address, an 8-bit write bus (MEM_DATA1) and an 8-bit read bus (MEM_DATA2).
- Reset loads a fixed boot image so the CPU has a program to fetch immediately after reset release.

---
 rtl/cisc_memory.sv | 63 ++++++
 tb/tb_cisc_memory.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/cisc_memory.sv
// rtl/cisc_memory.sv - 32x8 single-port CISC data/instruction memory with boot image
module cisc_memory #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              READ,
  input  logic              WRITE,
  input  logic [ADDR_W-1:0] MEM_ADDR,
  input  logic [DATA_W-1:0] MEM_DATA1,
  output logic [DATA_W-1:0] MEM_DATA2
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;
  logic              w_do_write;
  logic              w_do_read;

  // Boot program the CPU fetches right after reset release; all other words clear.
  function automatic logic [DATA_W-1:0] f_boot(input int idx);
    logic [DATA_W-1:0] v;
    case (idx)
      0:       v = DATA_W'(8'h20);
      1:       v = DATA_W'(8'h41);
      2:       v = DATA_W'(8'h62);
      3:       v = DATA_W'(8'hE0);
      default: v = '0;
    endcase
    return v;
  endfunction

  // Write has priority over read when both strobes are high.
  always_comb begin
    w_do_write = WRITE;
    w_do_read  = READ & ~WRITE;
  end

  // Storage array: reset reloads the boot image, writes update one word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= f_boot(i);
      end
    end else if (w_do_write) begin
      r_mem[MEM_ADDR] <= MEM_DATA1;
    end
  end

  // Registered read port: updates only on a read-only cycle, otherwise holds.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rdata <= '0;
    end else if (w_do_read) begin
      r_rdata <= r_mem[MEM_ADDR];
    end
  end

  assign MEM_DATA2 = r_rdata;

endmodule

// File: tb/tb_cisc_memory.sv
// tb/tb_cisc_memory.sv - randomized self-checking bench for cisc_memory
module tb_cisc_memory;

  logic       clk;
  logic       reset;
  logic       rd;
  logic       wr;
  logic [4:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;

  int checks;
  int errors;

  logic [7:0] m_mem [32];
  logic [7:0] m_q;

  cisc_memory dut (
    .clk       (clk),
    .reset     (reset),
    .READ      (rd),
    .WRITE     (wr),
    .MEM_ADDR  (addr),
    .MEM_DATA1 (wdata),
    .MEM_DATA2 (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_mem[i] = 8'h00;
    m_mem[0] = 8'h20;
    m_mem[1] = 8'h41;
    m_mem[2] = 8'h62;
    m_mem[3] = 8'hE0;
    m_q = 8'h00;
  endtask

  // One bus cycle: drive on the falling edge, let the rising edge act, then
  // advance the reference model and leave time for sampling just after the edge.
  task automatic cyc(input logic r, input logic w, input logic [5:0] a6, input logic [7:0] d);
    logic [4:0] a;
    a = a6[4:0];
    @(negedge clk);
    rd = r; wr = w; addr = a; wdata = d;
    @(posedge clk);
    #1;
    if (w) m_mem[a] = d;
    else if (r) m_q = m_mem[a];
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rd = 0; wr = 0; addr = '0; wdata = '0;
    reset = 1'b0;
    model_reset();

    // reset state
    repeat (2) @(posedge clk);
    #1 check("reset_q", rdata, 8'h00);
    @(negedge clk) reset = 1'b1;

    // boot image, one-cycle read latency
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 6'(i), 8'h00);
      check($sformatf("boot_rd%0d", i), rdata, m_q);
    end
    check("boot_rd3_const", rdata, 8'hE0);

    // write then read
    cyc(0, 1, 6'd4, 8'hA5);
    check("wr4_hold", rdata, 8'hE0);
    cyc(0, 1, 6'd26, 8'h3C);
    check("wr26_hold", rdata, 8'hE0);
    cyc(1, 0, 6'd4, 8'h00);
    check("rd4", rdata, 8'hA5);
    cyc(1, 0, 6'd26, 8'h00);
    check("rd26", rdata, 8'h3C);

    // prefill with FF, overwrite with zero (address 26 via wide 6-bit value)
    cyc(0, 1, 6'd26, 8'hFF);
    cyc(0, 1, 6'd27, 8'hFF);
    cyc(0, 1, 6'd28, 8'hFF);
    cyc(0, 1, 6'd30, 8'hFF);
    cyc(1, 0, 6'd30, 8'h00);
    check("rd30_ff", rdata, 8'hFF);
    cyc(0, 1, 6'b111010, 8'h00);
    cyc(0, 1, 6'd27, 8'h00);
    cyc(0, 1, 6'd28, 8'h00);
    cyc(0, 1, 6'd30, 8'h00);
    check("zero_wr_hold", rdata, 8'hFF);
    cyc(1, 0, 6'd26, 8'h00); check("rd26_zero", rdata, 8'h00);
    cyc(1, 0, 6'd30, 8'h00); check("rd30_zero", rdata, 8'h00);
    cyc(1, 0, 6'd28, 8'h00); check("rd28_zero", rdata, 8'h00);
    cyc(1, 0, 6'd27, 8'h00); check("rd27_zero", rdata, 8'h00);

    // simultaneous strobes: write wins, output holds
    cyc(1, 0, 6'd3, 8'h00);
    check("pre_both", rdata, 8'hE0);
    cyc(1, 1, 6'd1, 8'h77);
    check("both_hold", rdata, 8'hE0);
    cyc(1, 0, 6'd1, 8'h00);
    check("both_rd1", rdata, 8'h77);

    // idle hold
    cyc(1, 0, 6'd2, 8'h00);
    check("idle_rd2", rdata, 8'h62);
    cyc(0, 0, 6'd5, 8'h00);
    check("idle_hold1", rdata, 8'h62);
    cyc(0, 0, 6'd5, 8'h00);
    check("idle_hold2", rdata, 8'h62);

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic [1:0] op;
      op = 2'($urandom_range(0, 3));
      cyc(op[0], op[1], 6'($urandom), 8'($urandom));
      check("rand_q", rdata, m_q);
    end
    for (int i = 0; i < 32; i++) begin
      cyc(1, 0, 6'(i), 8'h00);
      check($sformatf("sweep%0d", i), rdata, m_q);
    end

    // asynchronous reset mid-operation
    cyc(0, 1, 6'd0, 8'h99);
    cyc(1, 0, 6'd0, 8'h00);
    check("pre_areset_rd0", rdata, 8'h99);
    #2 reset = 1'b0;
    #1 check("areset_q", rdata, 8'h00);
    model_reset();
    @(negedge clk) reset = 1'b1;
    cyc(1, 0, 6'd0, 8'h00);
    check("post_areset_rd0", rdata, 8'h20);
    for (int i = 1; i < 32; i++) begin
      cyc(1, 0, 6'(i), 8'h00);
      check($sformatf("post_sweep%0d", i), rdata, m_q);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
